// File: rtl/altera_tse_tx_encap_pkg.sv
// Shared definitions for the 1000BASE-X PCS transmit code-group generator:
// code-group constants and the ordered-set state enum.
package altera_tse_tx_encap_pkg;

    // K-characters
    localparam logic [7:0] K28_5   = 8'hBC;  // comma, first octet of /I/ and /C/
    localparam logic [7:0] K_SOP   = 8'hFB;  // /S/ start of packet
    localparam logic [7:0] K_EOP_T = 8'hFD;  // /T/ end of packet
    localparam logic [7:0] K_EXT_R = 8'hF7;  // /R/ carrier extend
    localparam logic [7:0] K_ERR_V = 8'hFE;  // /V/ error propagation

    // D-characters
    localparam logic [7:0] D5_6    = 8'hC5;  // /I1/ second octet, corrects positive disparity
    localparam logic [7:0] D16_2   = 8'h50;  // /I2/ second octet, preserves negative disparity
    localparam logic [7:0] D21_5   = 8'hB5;  // /C1/ second octet
    localparam logic [7:0] D2_2    = 8'h42;  // /C2/ second octet

    // One state per code-group position of every ordered set we can emit.
    typedef enum logic [3:0] {
        IDLE_K,
        IDLE_D,
        SOP,
        DATA,
        EOP_T,
        EOP_R1,
        EOP_R2,
        CFG_K,
        CFG_D,
        CFG_LO,
        CFG_HI
    } tx_state_e;

    // Second octet of an idle: /I1/ flips a positive disparity back to
    // negative, /I2/ keeps an already negative disparity.
    function automatic logic [7:0] idle_data(input logic rundisp_pos);
        return rundisp_pos ? D5_6 : D16_2;
    endfunction

endpackage

// File: rtl/altera_std_synchronizer.sv
// Multi-stage flip-flop synchroniser for a single asynchronous level signal.
// depth must be at least 2.
module altera_std_synchronizer #(
    parameter int depth = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [depth-1:0] sync_q;
    logic [depth-1:0] sync_d;

    // Shift the asynchronous input one stage further down the chain.
    always_comb begin
        sync_d = {sync_q[depth-2:0], din};
    end

    // Synchroniser flops, cleared while reset is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[depth-1];

endmodule

// File: rtl/altera_tse_tx_stats.sv
// Transmit statistics: frames sent (one per /T/) and /V/ code-groups sent.
// Both counters wrap from 0xFFFF to 0.
module altera_tse_tx_stats
    import altera_tse_tx_encap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_inc,
    input  logic        err_inc,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Advance each counter on its event pulse; natural 16-bit wrap.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (frame_inc) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (err_inc) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: rtl/altera_tse_tx_encapsulation.sv
// 1000BASE-X PCS transmit code-group generator. Turns GMII transmit octets
// into code-groups plus a K flag for the GXB 8b/10b encoder, inserting idle,
// start, terminate, carrier-extend, error and auto-negotiation config sets.
// Optional statistics counters are built when TSE_TX_STATS_EN is defined;
// otherwise tx_frame_cnt and tx_err_cnt are tied to zero.
module altera_tse_tx_encapsulation
    import altera_tse_tx_encap_pkg::*;
#(
    parameter int SYNCHRONIZER_DEPTH = 3
) (
    input  logic        tx_clk,
    input  logic        reset_tx_clk,
    input  logic [7:0]  gmii_tx_d,
    input  logic        gmii_tx_en,
    input  logic        gmii_tx_err,
    input  logic        xmit_cfg,
    input  logic [15:0] tx_config_reg,
    input  logic        tx_rundisp_pos,
    output logic [7:0]  tx_frame,
    output logic        tx_kchar,
    output logic        tx_even,
    output logic        transmitting,
    output logic [15:0] tx_frame_cnt,
    output logic [15:0] tx_err_cnt
);

    // GMII input stage
    logic [7:0]  txd_q;
    logic        txen_q;
    logic        txerr_q;
    logic        txen_prev_q;

    // Synchronised configuration-mode request
    logic        reset_n;
    logic        xmit_cfg_sync;

    // Ordered-set state and registered outputs
    tx_state_e   state_q, state_d;
    tx_state_e   emit_state;
    logic        c2_sel_q, c2_sel_d;
    logic [15:0] cfg_word_q, cfg_word_d;
    logic [7:0]  tx_frame_q, tx_frame_d;
    logic        tx_kchar_q, tx_kchar_d;
    logic        tx_even_q, tx_even_d;
    logic        transmitting_q, transmitting_d;

    logic        slot_even;
    logic        en_rise;
    tx_state_e   boundary_state;

    assign reset_n = ~reset_tx_clk;

    altera_std_synchronizer #(
        .depth (SYNCHRONIZER_DEPTH)
    ) u_xmit_cfg_sync (
        .clk     (tx_clk),
        .reset_n (reset_n),
        .din     (xmit_cfg),
        .dout    (xmit_cfg_sync)
    );

    // Register the GMII inputs once and keep the previous enable for edge detection.
    always_ff @(posedge tx_clk or posedge reset_tx_clk) begin
        if (reset_tx_clk) begin
            txd_q       <= '0;
            txen_q      <= 1'b0;
            txerr_q     <= 1'b0;
            txen_prev_q <= 1'b0;
        end else begin
            txd_q       <= gmii_tx_d;
            txen_q      <= gmii_tx_en;
            txerr_q     <= gmii_tx_err;
            txen_prev_q <= txen_q;
        end
    end

    // Resolve which code-group position is emitted this slot: a start or an
    // end of packet replaces the octet in the pipeline at that very slot.
    always_comb begin
        slot_even      = ~tx_even_q;
        en_rise        = txen_q & ~txen_prev_q;
        boundary_state = xmit_cfg_sync ? CFG_K : IDLE_K;
        emit_state     = state_q;
        if ((state_q == IDLE_K) && en_rise) begin
            emit_state = SOP;
        end else if ((state_q == DATA) && !txen_q) begin
            emit_state = EOP_T;
        end
    end

    // Code-group selection and next-state decision for the slot being emitted.
    always_comb begin
        state_d        = state_q;
        c2_sel_d       = c2_sel_q;
        cfg_word_d     = cfg_word_q;
        tx_frame_d     = K28_5;
        tx_kchar_d     = 1'b1;
        tx_even_d      = ~tx_even_q;
        transmitting_d = 1'b0;

        case (emit_state)
            IDLE_K: begin
                tx_frame_d = K28_5;
                tx_kchar_d = 1'b1;
                state_d    = IDLE_D;
            end
            IDLE_D: begin
                tx_frame_d = idle_data(tx_rundisp_pos);
                tx_kchar_d = 1'b0;
                state_d    = en_rise ? SOP : boundary_state;
            end
            SOP: begin
                tx_frame_d     = K_SOP;
                tx_kchar_d     = 1'b1;
                transmitting_d = 1'b1;
                state_d        = DATA;
            end
            DATA: begin
                tx_frame_d     = txerr_q ? K_ERR_V : txd_q;
                tx_kchar_d     = txerr_q;
                transmitting_d = 1'b1;
                state_d        = DATA;
            end
            EOP_T: begin
                tx_frame_d     = K_EOP_T;
                tx_kchar_d     = 1'b1;
                transmitting_d = 1'b1;
                state_d        = EOP_R1;
            end
            EOP_R1: begin
                tx_frame_d     = K_EXT_R;
                tx_kchar_d     = 1'b1;
                transmitting_d = 1'b1;
                state_d        = slot_even ? EOP_R2 : boundary_state;
            end
            EOP_R2: begin
                tx_frame_d     = K_EXT_R;
                tx_kchar_d     = 1'b1;
                transmitting_d = 1'b1;
                state_d        = boundary_state;
            end
            CFG_K: begin
                tx_frame_d = K28_5;
                tx_kchar_d = 1'b1;
                cfg_word_d = tx_config_reg;
                state_d    = CFG_D;
            end
            CFG_D: begin
                tx_frame_d = c2_sel_q ? D2_2 : D21_5;
                tx_kchar_d = 1'b0;
                state_d    = CFG_LO;
            end
            CFG_LO: begin
                tx_frame_d = cfg_word_q[7:0];
                tx_kchar_d = 1'b0;
                state_d    = CFG_HI;
            end
            CFG_HI: begin
                tx_frame_d = cfg_word_q[15:8];
                tx_kchar_d = 1'b0;
                if (xmit_cfg_sync) begin
                    c2_sel_d = ~c2_sel_q;
                    state_d  = CFG_K;
                end else begin
                    c2_sel_d = 1'b0;
                    state_d  = IDLE_K;
                end
            end
            default: begin
                tx_frame_d = K28_5;
                tx_kchar_d = 1'b1;
                state_d    = IDLE_D;
            end
        endcase
    end

    // Ordered-set state machine with registered code-group outputs.
    always_ff @(posedge tx_clk or posedge reset_tx_clk) begin
        if (reset_tx_clk) begin
            state_q        <= IDLE_D;
            c2_sel_q       <= 1'b0;
            cfg_word_q     <= '0;
            tx_frame_q     <= K28_5;
            tx_kchar_q     <= 1'b1;
            tx_even_q      <= 1'b1;
            transmitting_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            c2_sel_q       <= c2_sel_d;
            cfg_word_q     <= cfg_word_d;
            tx_frame_q     <= tx_frame_d;
            tx_kchar_q     <= tx_kchar_d;
            tx_even_q      <= tx_even_d;
            transmitting_q <= transmitting_d;
        end
    end

    assign tx_frame     = tx_frame_q;
    assign tx_kchar     = tx_kchar_q;
    assign tx_even      = tx_even_q;
    assign transmitting = transmitting_q;

`ifdef TSE_TX_STATS_EN
    logic frame_inc;
    logic err_inc;

    assign frame_inc = (emit_state == EOP_T);
    assign err_inc   = (emit_state == DATA) && txerr_q;

    altera_tse_tx_stats u_stats (
        .clk       (tx_clk),
        .rst       (reset_tx_clk),
        .frame_inc (frame_inc),
        .err_inc   (err_inc),
        .frame_cnt (tx_frame_cnt),
        .err_cnt   (tx_err_cnt)
    );
`else
    assign tx_frame_cnt = '0;
    assign tx_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_altera_tse_tx_encapsulation.sv
// Directed self-checking bench for altera_tse_tx_encapsulation.
// Every output sample is logged one time unit after the rising edge together
// with the slot parity the bench expects, and checks read back that log.
module tb_altera_tse_tx_encapsulation;

    localparam int LOGLEN = 1024;

`ifdef TSE_TX_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        tx_clk = 1'b0;
    logic        reset_tx_clk;
    logic [7:0]  gmii_tx_d;
    logic        gmii_tx_en;
    logic        gmii_tx_err;
    logic        xmit_cfg;
    logic [15:0] tx_config_reg;
    logic        tx_rundisp_pos;
    logic [7:0]  tx_frame;
    logic        tx_kchar;
    logic        tx_even;
    logic        transmitting;
    logic [15:0] tx_frame_cnt;
    logic [15:0] tx_err_cnt;

    int checks   = 0;
    int failures = 0;
    int n        = 0;
    logic expEven = 1'b1;

    logic [7:0] logFrame   [0:LOGLEN-1];
    logic       logK       [0:LOGLEN-1];
    logic       logEven    [0:LOGLEN-1];
    logic       logExpEven [0:LOGLEN-1];
    logic       logTx      [0:LOGLEN-1];

    altera_tse_tx_encapsulation #(
        .SYNCHRONIZER_DEPTH (3)
    ) dut (
        .tx_clk         (tx_clk),
        .reset_tx_clk   (reset_tx_clk),
        .gmii_tx_d      (gmii_tx_d),
        .gmii_tx_en     (gmii_tx_en),
        .gmii_tx_err    (gmii_tx_err),
        .xmit_cfg       (xmit_cfg),
        .tx_config_reg  (tx_config_reg),
        .tx_rundisp_pos (tx_rundisp_pos),
        .tx_frame       (tx_frame),
        .tx_kchar       (tx_kchar),
        .tx_even        (tx_even),
        .transmitting   (transmitting),
        .tx_frame_cnt   (tx_frame_cnt),
        .tx_err_cnt     (tx_err_cnt)
    );

    // 125 MHz-style free-running clock, 10 time units per period.
    always #5 tx_clk = ~tx_clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Wait one rising edge, then log the outputs and the model's slot parity.
    task automatic stepCycle();
        @(posedge tx_clk);
        #1;
        expEven = reset_tx_clk ? 1'b1 : ~expEven;
        if (n < LOGLEN) begin
            logFrame[n]   = tx_frame;
            logK[n]       = tx_kchar;
            logEven[n]    = tx_even;
            logExpEven[n] = expEven;
            logTx[n]      = transmitting;
        end
        n++;
    endtask

    // Drive one GMII octet for the next edge and advance a cycle.
    task automatic applyStimulus(input logic [7:0] d, input logic en, input logic err);
        gmii_tx_d   = d;
        gmii_tx_en  = en;
        gmii_tx_err = err;
        stepCycle();
    endtask

    task automatic idleCycles(input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(8'h00, 1'b0, 1'b0);
        end
    endtask

    // Burn one idle cycle if needed so the latest logged slot has the wanted parity.
    task automatic alignTo(input logic wantEven);
        if (expEven !== wantEven) begin
            applyStimulus(8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Compare a logged slot against {model parity, K, octet}.
    task automatic checkOutputLog(input string tag, input int idx, input logic [7:0] f, input logic k);
        checkOutput(tag, {22'd0, logEven[idx], logK[idx], logFrame[idx]},
                         {22'd0, logExpEven[idx], k, f});
    endtask

    // An idle slot is /K28.5/ when even, otherwise the disparity-dependent D octet.
    task automatic checkIdleLog(input string tag, input int idx, input logic rdPos);
        if (logExpEven[idx]) begin
            checkOutputLog(tag, idx, 8'hBC, 1'b1);
        end else begin
            checkOutputLog(tag, idx, rdPos ? 8'hC5 : 8'h50, 1'b0);
        end
    endtask

    initial begin
        int  s;
        int  j;
        logic found;

        reset_tx_clk   = 1'b1;
        gmii_tx_d      = 8'h00;
        gmii_tx_en     = 1'b0;
        gmii_tx_err    = 1'b0;
        xmit_cfg       = 1'b0;
        tx_config_reg  = 16'h0000;
        tx_rundisp_pos = 1'b0;

        // Reset values
        stepCycle();
        stepCycle();
        checkOutput("rst_frame", {24'd0, tx_frame}, 32'hBC);
        checkOutput("rst_kchar", {31'd0, tx_kchar}, 32'd1);
        checkOutput("rst_even", {31'd0, tx_even}, 32'd1);
        checkOutput("rst_transmitting", {31'd0, transmitting}, 32'd0);
        checkOutput("rst_frame_cnt", {16'd0, tx_frame_cnt}, 32'd0);
        checkOutput("rst_err_cnt", {16'd0, tx_err_cnt}, 32'd0);

        // Idle with negative disparity: leaves reset in IDLE_D, so 50 first
        reset_tx_clk = 1'b0;
        s = n;
        idleCycles(4);
        checkOutputLog("idle_neg_0", s, 8'h50, 1'b0);
        checkOutputLog("idle_neg_1", s + 1, 8'hBC, 1'b1);
        checkOutputLog("idle_neg_2", s + 2, 8'h50, 1'b0);
        checkOutputLog("idle_neg_3", s + 3, 8'hBC, 1'b1);

        // Idle with positive disparity
        tx_rundisp_pos = 1'b1;
        s = n;
        idleCycles(4);
        for (int i = 0; i < 4; i++) begin
            checkIdleLog("idle_pos", s + i, 1'b1);
        end
        tx_rundisp_pos = 1'b0;

        // 8-octet frame starting on an even slot
        alignTo(1'b1);
        s = n;
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i == 7) ? 8'hD5 : 8'h55, 1'b1, 1'b0);
        end
        idleCycles(8);
        checkOutput("f8_pre_tx", {31'd0, logTx[s]}, 32'd0);
        checkOutputLog("f8_sop", s + 1, 8'hFB, 1'b1);
        checkOutput("f8_sop_tx", {31'd0, logTx[s + 1]}, 32'd1);
        for (int i = 1; i <= 7; i++) begin
            checkOutputLog("f8_data", s + 1 + i, (i == 7) ? 8'hD5 : 8'h55, 1'b0);
        end
        checkOutputLog("f8_term", s + 9, 8'hFD, 1'b1);
        checkOutputLog("f8_ext", s + 10, 8'hF7, 1'b1);
        checkOutput("f8_ext_tx", {31'd0, logTx[s + 10]}, 32'd1);
        checkOutputLog("f8_idle", s + 11, 8'hBC, 1'b1);
        checkOutput("f8_idle_tx", {31'd0, logTx[s + 11]}, 32'd0);
        checkOutput("f8_frame_cnt", {16'd0, tx_frame_cnt}, STATS * 1);

        // 9-octet frame: /T/ lands odd, /R/ even, so a second /R/ follows
        alignTo(1'b1);
        s = n;
        for (int i = 0; i < 9; i++) begin
            applyStimulus((i == 8) ? 8'h11 : ((i == 7) ? 8'hD5 : 8'h55), 1'b1, 1'b0);
        end
        idleCycles(8);
        checkOutputLog("f9_sop", s + 1, 8'hFB, 1'b1);
        checkOutputLog("f9_data7", s + 8, 8'hD5, 1'b0);
        checkOutputLog("f9_data8", s + 9, 8'h11, 1'b0);
        checkOutputLog("f9_term", s + 10, 8'hFD, 1'b1);
        checkOutputLog("f9_ext1", s + 11, 8'hF7, 1'b1);
        checkOutputLog("f9_ext2", s + 12, 8'hF7, 1'b1);
        checkOutput("f9_ext2_tx", {31'd0, logTx[s + 12]}, 32'd1);
        checkOutputLog("f9_idle", s + 13, 8'hBC, 1'b1);
        checkOutput("f9_frame_cnt", {16'd0, tx_frame_cnt}, STATS * 2);

        // Odd-slot start: idle completes, first octet dropped, /S/ replaces the second
        alignTo(1'b0);
        s = n;
        applyStimulus(8'hA1, 1'b1, 1'b0);
        applyStimulus(8'hA2, 1'b1, 1'b0);
        applyStimulus(8'hA3, 1'b1, 1'b0);
        applyStimulus(8'hA4, 1'b1, 1'b0);
        idleCycles(10);
        checkOutputLog("odd_idle", s + 1, 8'h50, 1'b0);
        checkOutputLog("odd_sop", s + 2, 8'hFB, 1'b1);
        checkOutputLog("odd_data3", s + 3, 8'hA3, 1'b0);
        checkOutputLog("odd_data4", s + 4, 8'hA4, 1'b0);
        checkOutputLog("odd_term", s + 5, 8'hFD, 1'b1);
        checkOutputLog("odd_ext1", s + 6, 8'hF7, 1'b1);
        checkOutputLog("odd_ext2", s + 7, 8'hF7, 1'b1);
        checkOutputLog("odd_idle_after", s + 8, 8'hBC, 1'b1);

        // Error on data octet 4 becomes /V/
        alignTo(1'b1);
        s = n;
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i == 7) ? 8'hD5 : 8'h55, 1'b1, (i == 4) ? 1'b1 : 1'b0);
        end
        idleCycles(8);
        checkOutputLog("err_data3", s + 4, 8'h55, 1'b0);
        checkOutputLog("err_vchar", s + 5, 8'hFE, 1'b1);
        checkOutputLog("err_data5", s + 6, 8'h55, 1'b0);
        checkOutputLog("err_term", s + 9, 8'hFD, 1'b1);
        checkOutput("err_err_cnt", {16'd0, tx_err_cnt}, STATS * 1);
        checkOutput("err_frame_cnt", {16'd0, tx_frame_cnt}, STATS * 4);

        // gmii_tx_err without enable is ignored
        s = n;
        applyStimulus(8'hEE, 1'b0, 1'b1);
        applyStimulus(8'hEE, 1'b0, 1'b1);
        idleCycles(3);
        for (int i = 1; i <= 4; i++) begin
            checkIdleLog("err_noen_idle", s + i, 1'b0);
        end
        checkOutput("err_noen_cnt", {16'd0, tx_err_cnt}, STATS * 1);

        // Configuration mode: /C1/ /C2/ alternate carrying 0x01A0
        tx_config_reg = 16'h01A0;
        xmit_cfg      = 1'b1;
        s = n;
        idleCycles(30);
        found = 1'b0;
        j = s + 1;
        for (int i = s + 1; i <= s + 20; i++) begin
            if (!found && logFrame[i] === 8'hB5 && logK[i] === 1'b0) begin
                found = 1'b1;
                j = i;
            end
        end
        checkOutput("cfg_found", {31'd0, found}, 32'd1);
        if (found) begin
            checkOutputLog("cfg_c1_k", j - 1, 8'hBC, 1'b1);
            checkOutputLog("cfg_c1_d", j, 8'hB5, 1'b0);
            checkOutputLog("cfg_c1_lo", j + 1, 8'hA0, 1'b0);
            checkOutputLog("cfg_c1_hi", j + 2, 8'h01, 1'b0);
            checkOutputLog("cfg_c2_k", j + 3, 8'hBC, 1'b1);
            checkOutputLog("cfg_c2_d", j + 4, 8'h42, 1'b0);
            checkOutputLog("cfg_c2_lo", j + 5, 8'hA0, 1'b0);
            checkOutputLog("cfg_c2_hi", j + 6, 8'h01, 1'b0);
            checkOutputLog("cfg_c1b_d", j + 8, 8'hB5, 1'b0);
            checkOutput("cfg_tx", {31'd0, logTx[j]}, 32'd0);
        end
        xmit_cfg = 1'b0;
        idleCycles(14);
        checkIdleLog("cfg_exit_idle_a", n - 2, 1'b0);
        checkIdleLog("cfg_exit_idle_b", n - 1, 1'b0);

        // xmit_cfg asserted mid-packet: the packet completes, then config begins
        alignTo(1'b1);
        s = n;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                xmit_cfg = 1'b1;
            end
            applyStimulus((i == 7) ? 8'hD5 : 8'h55, 1'b1, 1'b0);
        end
        idleCycles(6);
        checkOutputLog("mid_sop", s + 1, 8'hFB, 1'b1);
        checkOutputLog("mid_data", s + 5, 8'h55, 1'b0);
        checkOutputLog("mid_data_last", s + 8, 8'hD5, 1'b0);
        checkOutputLog("mid_term", s + 9, 8'hFD, 1'b1);
        checkOutputLog("mid_ext", s + 10, 8'hF7, 1'b1);
        checkOutputLog("mid_cfg_k", s + 11, 8'hBC, 1'b1);
        checkOutputLog("mid_cfg_d", s + 12, 8'hB5, 1'b0);
        xmit_cfg = 1'b0;
        idleCycles(14);

        // Reset mid-packet: outputs return at once to reset values
        alignTo(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h55, 1'b1, 1'b0);
        end
        checkOutput("rstmid_pre_tx", {31'd0, transmitting}, 32'd1);
        gmii_tx_en   = 1'b0;
        reset_tx_clk = 1'b1;
        #1;
        checkOutput("rstmid_frame", {24'd0, tx_frame}, 32'hBC);
        checkOutput("rstmid_kchar", {31'd0, tx_kchar}, 32'd1);
        checkOutput("rstmid_even", {31'd0, tx_even}, 32'd1);
        checkOutput("rstmid_tx", {31'd0, transmitting}, 32'd0);
        checkOutput("rstmid_frame_cnt", {16'd0, tx_frame_cnt}, 32'd0);
        stepCycle();
        reset_tx_clk = 1'b0;
        s = n;
        idleCycles(4);
        checkOutputLog("rstmid_resume_0", s, 8'h50, 1'b0);
        checkOutputLog("rstmid_resume_1", s + 1, 8'hBC, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
